// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : Receive-side controller: enable/drain/soft-reset sequencing,
//             show-ahead frame FIFO, sticky error flags and level interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DEPTH       = 4,
    parameter int SRST_CYCLES = 2,
    parameter int DRAIN_TMO   = 4096
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         cfg_wr,
    input  logic [2:0]                   cfg_wdata,
    input  logic                         rx_done,
    input  logic                         rx_error,
    input  logic                         rx_busy,
    input  logic [7:0]                   rx_data,
    output logic                         rx_en,
    output logic                         rx_srst,
    input  logic                         rd_pop,
    output logic [7:0]                   rd_data,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH):0]       fifo_level,
    input  logic                         clr_ovr,
    input  logic                         clr_ferr,
    output logic                         overrun,
    output logic                         frame_err,
    output logic                         irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(DRAIN_TMO + 1);
    localparam int SW = $clog2(SRST_CYCLES + 1);

    localparam logic [1:0] c_st_disabled = 2'd0;
    localparam logic [1:0] c_st_enabled  = 2'd1;
    localparam logic [1:0] c_st_drain    = 2'd2;
    localparam logic [1:0] c_st_reset    = 2'd3;

    localparam logic [TW-1:0] c_tmo_last  = TW'(DRAIN_TMO - 1);
    localparam logic [SW-1:0] c_srst_last = SW'(SRST_CYCLES - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic [SW-1:0] r_srst_cnt;
    logic          w_srst_wr;
    logic          w_reset_entry;
    logic          w_accept;
    logic          w_rx_en_nxt;
    logic          w_rx_srst_nxt;

    logic [7:0]    r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_req;
    logic          w_do_push;
    logic          w_ovr_set;
    logic          w_ferr_set;

    logic          r_rx_en;
    logic          r_rx_srst;
    logic          r_irq_en;
    logic          r_overrun;
    logic          r_frame_err;
    logic          r_irq;

    assign w_srst_wr = cfg_wr & cfg_wdata[1];
    assign w_accept  = (r_state == c_st_enabled) || (r_state == c_st_drain);

    // State register
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= c_st_disabled;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a soft-reset write overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_disabled: begin
                if (cfg_wr && cfg_wdata[0]) w_state_nxt = c_st_enabled;
            end
            c_st_enabled: begin
                if (cfg_wr && !cfg_wdata[0]) w_state_nxt = rx_busy ? c_st_drain : c_st_disabled;
            end
            c_st_drain: begin
                if (cfg_wr && cfg_wdata[0])    w_state_nxt = c_st_enabled;
                else if (!rx_busy)             w_state_nxt = c_st_disabled;
                else if (r_tmo_cnt == c_tmo_last) w_state_nxt = c_st_reset;
            end
            c_st_reset: begin
                if (r_srst_cnt == c_srst_last) w_state_nxt = c_st_disabled;
            end
            default: w_state_nxt = c_st_disabled;
        endcase
        if (w_srst_wr) w_state_nxt = c_st_reset;
    end

    // Outputs are registered from the next state so they move on the same edge as the state
    always_comb begin
        w_rx_en_nxt   = (w_state_nxt == c_st_enabled) || (w_state_nxt == c_st_drain);
        w_rx_srst_nxt = (w_state_nxt == c_st_reset);
    end

    assign w_reset_entry = (w_state_nxt == c_st_reset) && ((r_state != c_st_reset) || w_srst_wr);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_rx_en    <= 1'b0;
            r_rx_srst  <= 1'b0;
            r_tmo_cnt  <= '0;
            r_srst_cnt <= '0;
        end else begin
            r_rx_en   <= w_rx_en_nxt;
            r_rx_srst <= w_rx_srst_nxt;
            if ((r_state == c_st_drain) && (w_state_nxt == c_st_drain))
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            else
                r_tmo_cnt <= '0;
            if (w_reset_entry)
                r_srst_cnt <= '0;
            else if (r_state == c_st_reset)
                r_srst_cnt <= r_srst_cnt + SW'(1);
            else
                r_srst_cnt <= '0;
        end
    end

    // FIFO: a full FIFO still accepts a push when the head is popped in the same cycle
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = rd_pop & ~w_empty;
    assign w_push_req = rx_done & w_accept;
    assign w_do_push  = w_push_req & (~w_full | w_pop);
    assign w_ovr_set  = w_push_req & w_full & ~w_pop;
    assign w_ferr_set = rx_error & w_accept;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_reset_entry) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Sticky flags: a set beats a simultaneous clear, a reset entry beats both
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_reset_entry) begin
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
                r_irq_en    <= 1'b0;
            end else begin
                r_overrun   <= w_ovr_set  | (r_overrun   & ~clr_ovr);
                r_frame_err <= w_ferr_set | (r_frame_err & ~clr_ferr);
                if (cfg_wr && (r_state != c_st_reset)) r_irq_en <= cfg_wdata[2];
            end
            r_irq <= r_irq_en & (~w_empty | r_overrun | r_frame_err);
        end
    end

    assign rx_en      = r_rx_en;
    assign rx_srst    = r_rx_srst;
    assign rd_valid   = ~w_empty;
    assign rd_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign fifo_level = r_wr_ptr - r_rd_ptr;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;
    assign irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Directed self-checking bench for uart_rx_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int DEPTH       = 4;
    localparam int SRST_CYCLES = 2;
    localparam int DRAIN_TMO   = 4096;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [2:0] cfg_wdata = 3'b000;
    logic       rx_done = 1'b0;
    logic       rx_error = 1'b0;
    logic       rx_busy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en;
    logic       rx_srst;
    logic       rd_pop = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_level;
    logic       clr_ovr = 1'b0;
    logic       clr_ferr = 1'b0;
    logic       overrun;
    logic       frame_err;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_ctrl #(
        .DEPTH      (DEPTH),
        .SRST_CYCLES(SRST_CYCLES),
        .DRAIN_TMO  (DRAIN_TMO)
    ) u_dut (
        .clk       (clk),
        .arst      (arst),
        .cfg_wr    (cfg_wr),
        .cfg_wdata (cfg_wdata),
        .rx_done   (rx_done),
        .rx_error  (rx_error),
        .rx_busy   (rx_busy),
        .rx_data   (rx_data),
        .rx_en     (rx_en),
        .rx_srst   (rx_srst),
        .rd_pop    (rd_pop),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .fifo_level(fifo_level),
        .clr_ovr   (clr_ovr),
        .clr_ferr  (clr_ferr),
        .overrun   (overrun),
        .frame_err (frame_err),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [2:0] w);
        cfg_wr = 1'b1; cfg_wdata = w;
        tick();
        cfg_wr = 1'b0; cfg_wdata = 3'b000;
    endtask

    task automatic push(input logic [7:0] d);
        rx_done = 1'b1; rx_data = d;
        tick();
        rx_done = 1'b0; rx_data = 8'h00;
    endtask

    task automatic pop();
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
    endtask

    initial begin
        int n;
        int m;
        logic [7:0] exp_b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_en", rx_en, 0);
        check("rst_rx_srst", rx_srst, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_irq", irq, 0);
        check("rst_flags", {overrun, frame_err}, 0);
        arst = 1'b1;
        tick();

        // 1: enable and single push
        cfg(3'b001);
        check("t1_rx_en", rx_en, 1);
        push(8'hA5);
        check("t1_valid", rd_valid, 1);
        check("t1_data", rd_data, 8'hA5);
        check("t1_level", fifo_level, 1);
        pop();
        check("t1_level_after_pop", fifo_level, 0);

        // 2: overflow by one, then drain
        rx_done = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            rx_data = 8'(i);
            tick();
        end
        rx_done = 1'b0;
        check("t2_level", fifo_level, 4);
        check("t2_overrun", overrun, 1);
        check("t2_head", rd_data, 8'h01);
        check("t2_irq_masked", irq, 0);
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            check("t2_pop_data", rd_data, exp_b);
            pop();
        end
        check("t2_level_empty", fifo_level, 0);
        pop();
        check("t2_underflow_level", fifo_level, 0);
        check("t2_underflow_valid", rd_valid, 0);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        check("t2_clr_ovr", overrun, 0);

        // 3: push and pop together while full
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        check("t3_full_level", fifo_level, 4);
        rx_done = 1'b1; rx_data = 8'h14; rd_pop = 1'b1;
        tick();
        rx_done = 1'b0; rd_pop = 1'b0;
        check("t3_level", fifo_level, 4);
        check("t3_overrun", overrun, 0);
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'h10 + 8'(i);
            check("t3_pop_data", rd_data, exp_b);
            pop();
        end
        check("t3_empty", fifo_level, 0);

        // 4: drain completes when receiver goes idle
        rx_busy = 1'b1;
        cfg(3'b000);
        check("t4_drain_rx_en", rx_en, 1);
        push(8'h3C);
        check("t4_level", fifo_level, 1);
        check("t4_data", rd_data, 8'h3C);
        rx_busy = 1'b0;
        tick();
        check("t4_rx_en_off", rx_en, 0);
        check("t4_no_srst", rx_srst, 0);
        push(8'h77);
        check("t4_disabled_ignored", fifo_level, 1);
        rx_error = 1'b1; tick(); rx_error = 1'b0;
        check("t4_disabled_no_ferr", frame_err, 0);
        pop();

        // 5: drain timeout forces a soft reset
        cfg(3'b001);
        push(8'hAA);
        push(8'hBB);
        rx_busy = 1'b1;
        cfg(3'b000);
        n = 0;
        while (!rx_srst && n < DRAIN_TMO + 1000) begin
            tick();
            n++;
        end
        check("t5_tmo_cycles", n, DRAIN_TMO);
        check("t5_rx_en", rx_en, 0);
        check("t5_flushed", fifo_level, 0);
        check("t5_valid", rd_valid, 0);
        m = 0;
        while (rx_srst && m < 10) begin
            m++;
            tick();
        end
        check("t5_srst_len", m, SRST_CYCLES);
        check("t5_rx_en_after", rx_en, 0);
        rx_busy = 1'b0;

        // 6: soft reset clears flags, FIFO and interrupt
        cfg(3'b101);
        push(8'h01);
        push(8'h02);
        rx_error = 1'b1; tick(); rx_error = 1'b0;
        check("t6_ferr", frame_err, 1);
        check("t6_irq", irq, 1);
        rx_error = 1'b1; clr_ferr = 1'b1; tick(); rx_error = 1'b0; clr_ferr = 1'b0;
        check("t6_set_beats_clr", frame_err, 1);
        clr_ferr = 1'b1; tick(); clr_ferr = 1'b0;
        check("t6_clr_ferr", frame_err, 0);
        rx_error = 1'b1; tick(); rx_error = 1'b0;
        check("t6_ferr_again", frame_err, 1);
        check("t6_level2", fifo_level, 2);
        cfg(3'b111);
        check("t6_srst", rx_srst, 1);
        check("t6_rx_en", rx_en, 0);
        check("t6_level", fifo_level, 0);
        check("t6_flags", {overrun, frame_err}, 0);
        tick();
        check("t6_irq_off", irq, 0);
        repeat (3) tick();
        check("t6_srst_done", rx_srst, 0);
        check("t6_rx_en_stays_off", rx_en, 0);
        check("t6_irq_stays_off", irq, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
